// File: rtl/enable_code_sequencer_pkg.sv
// Shared constants for the enable-code sequencer and the downstream enable decoder.
// Code values, FSM state encoding and small mask helpers.
package enable_code_sequencer_pkg;

  localparam logic [2:0] CODE_NONE = 3'b000;
  localparam logic [2:0] CODE_S1S4 = 3'b001;
  localparam logic [2:0] CODE_S1S3 = 3'b010;
  localparam logic [2:0] CODE_S2S3 = 3'b100;

  localparam int unsigned DwellW = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StDrive = 2'b01,
    StGuard = 2'b10,
    StDone  = 2'b11
  } state_e;

  // Index of the lowest set bit; callers guarantee mask != 0.
  function automatic logic [1:0] lowest_bit(input logic [2:0] mask);
    logic [1:0] idx;
    if (mask[0]) begin
      idx = 2'd0;
    end else if (mask[1]) begin
      idx = 2'd1;
    end else begin
      idx = 2'd2;
    end
    return idx;
  endfunction

  // Selected bits strictly above position idx.
  function automatic logic [2:0] mask_above(input logic [2:0] mask, input logic [1:0] idx);
    logic [2:0] res;
    unique case (idx)
      2'd0:    res = {mask[2:1], 1'b0};
      2'd1:    res = {mask[2], 2'b00};
      default: res = 3'b000;
    endcase
    return res;
  endfunction

  function automatic logic [2:0] code_of(input logic [1:0] idx);
    logic [2:0] code;
    unique case (idx)
      2'd0:    code = CODE_S1S4;
      2'd1:    code = CODE_S1S3;
      2'd2:    code = CODE_S2S3;
      default: code = CODE_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// 8-bit down counter: synchronous clear, parallel load, count to zero; tc_o flags zero.
module dwell_counter
  import enable_code_sequencer_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [DwellW-1:0] load_val_i,
  input  logic              en_i,
  output logic              tc_o
);

  logic [DwellW-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == '0);

endmodule

// File: rtl/enable_code_sequencer.sv
// Plays the selected enable codes in ascending order, each held dwell+1 cycles,
// with a one-cycle all-off guard between codes. All outputs are registered.
module enable_code_sequencer
  import enable_code_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [2:0]        req_sel,
  input  logic [DwellW-1:0] dwell,
  input  logic              abort,
  output logic              A,
  output logic              B,
  output logic              C,
  output logic              req_ready,
  output logic              busy,
  output logic              done
);

  state_e            state_d, state_q;
  logic [2:0]        abc_d, abc_q;
  logic              ready_d, ready_q;
  logic              busy_d, busy_q;
  logic              done_d, done_q;
  logic [2:0]        mask_d, mask_q;
  logic [DwellW-1:0] dwell_d, dwell_q;
  logic [1:0]        idx_d, idx_q;

  logic              cnt_clr, cnt_load, cnt_en, cnt_tc;
  logic [DwellW-1:0] cnt_load_val;

  dwell_counter u_dwell_counter (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (cnt_clr),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (cnt_en),
    .tc_o       (cnt_tc)
  );

  always_comb begin
    state_d      = state_q;
    abc_d        = CODE_NONE;
    ready_d      = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    mask_d       = mask_q;
    dwell_d      = dwell_q;
    idx_d        = idx_q;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_en       = 1'b0;
    cnt_load_val = dwell_q;

    unique case (state_q)
      StIdle: begin
        ready_d = 1'b1;
        // abort is deliberately ignored here; an empty mask is accepted but dropped
        if (req_valid && (req_sel != 3'b000)) begin
          mask_d       = req_sel;
          dwell_d      = dwell;
          idx_d        = lowest_bit(req_sel);
          cnt_load     = 1'b1;
          cnt_load_val = dwell;
          state_d      = StDrive;
          abc_d        = code_of(lowest_bit(req_sel));
          busy_d       = 1'b1;
          ready_d      = 1'b0;
        end
      end

      StDrive: begin
        if (abort) begin
          state_d = StIdle;
          cnt_clr = 1'b1;
          ready_d = 1'b1;
        end else if (cnt_tc) begin
          if (mask_above(mask_q, idx_q) != 3'b000) begin
            state_d = StGuard;
            busy_d  = 1'b1;
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end else begin
          cnt_en = 1'b1;
          abc_d  = code_of(idx_q);
          busy_d = 1'b1;
        end
      end

      StGuard: begin
        if (abort) begin
          state_d = StIdle;
          cnt_clr = 1'b1;
          ready_d = 1'b1;
        end else begin
          idx_d    = lowest_bit(mask_above(mask_q, idx_q));
          state_d  = StDrive;
          abc_d    = code_of(lowest_bit(mask_above(mask_q, idx_q)));
          busy_d   = 1'b1;
          cnt_load = 1'b1;
        end
      end

      StDone: begin
        state_d = StIdle;
        ready_d = 1'b1;
      end

      default: begin
        state_d = StIdle;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      abc_q   <= CODE_NONE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mask_q  <= 3'b000;
      dwell_q <= '0;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      abc_q   <= abc_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      idx_q   <= idx_d;
    end
  end

  assign {A, B, C}  = abc_q;
  assign req_ready  = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_enable_code_sequencer.sv
// Bench for enable_code_sequencer: directed table, random requests and reset corner cases,
// all compared cycle by cycle against a trace model built from the sequencing rules.
module tb_enable_code_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [2:0] req_sel;
  logic [7:0] dwell;
  logic       abort;
  logic       a_o, b_o, c_o, req_ready, busy, done;

  int checks = 0;
  int errors = 0;

  enable_code_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_sel   (req_sel),
    .dwell     (dwell),
    .abort     (abort),
    .A         (a_o),
    .B         (b_o),
    .C         (c_o),
    .req_ready (req_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] abc;
    logic       busy;
    logic       done;
    logic       ready;
  } exp_t;

  typedef struct {
    logic [2:0] sel;
    int         dw;
    int         ab;       // trace index at which abort is held, -1 for none
    bit         ab_req;   // abort held together with the request
    int         exp_busy;
    int         exp_done;
    logic [2:0] exp_seen;
  } vec_t;

  localparam exp_t ExpIdle  = '{abc: 3'b000, busy: 1'b0, done: 1'b0, ready: 1'b1};
  localparam exp_t ExpGuard = '{abc: 3'b000, busy: 1'b1, done: 1'b0, ready: 1'b0};
  localparam exp_t ExpDone  = '{abc: 3'b000, busy: 1'b0, done: 1'b1, ready: 1'b0};

  exp_t exp_q[$];
  int   seen_busy, seen_done;
  logic [2:0] seen_codes;

  // Expected per-cycle outputs after the acceptance edge, ending with one idle cycle.
  function automatic void build_trace(input logic [2:0] sel, input int dw, input int ab);
    exp_t e;
    int   done_at;
    exp_q.delete();
    if (sel != 3'b000) begin
      for (int b = 0; b < 3; b++) begin
        if (sel[b]) begin
          e = '{abc: 3'(1 << b), busy: 1'b1, done: 1'b0, ready: 1'b0};
          for (int c = 0; c <= dw; c++) exp_q.push_back(e);
          if ((sel >> (b + 1)) != 3'b000) exp_q.push_back(ExpGuard);
        end
      end
      done_at = exp_q.size();
      exp_q.push_back(ExpDone);
      if (ab >= 0 && ab < done_at) begin
        while (exp_q.size() > ab + 1) void'(exp_q.pop_back());
      end
    end
    exp_q.push_back(ExpIdle);
  endfunction

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic sample(input string name, input exp_t e);
    logic [2:0] abc;
    abc = {a_o, b_o, c_o};
    check(name, {abc, busy, done, req_ready}, e);
    checks++;
    if (!(abc inside {3'b000, 3'b001, 3'b010, 3'b100})) begin
      errors++;
      $display("FAIL %s_legal: got code %b required one of 000/001/010/100", name, abc);
    end
    if (busy === 1'b1) seen_busy++;
    if (done === 1'b1) seen_done++;
    seen_codes |= abc;
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_req(input string name, input vec_t v, input bit summary);
    build_trace(v.sel, v.dw, v.ab);
    seen_busy  = 0;
    seen_done  = 0;
    seen_codes = 3'b000;
    req_valid  = 1'b1;
    req_sel    = v.sel;
    dwell      = 8'(v.dw);
    abort      = v.ab_req;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      sample($sformatf("%s_cyc%0d", name, i), exp_q[i]);
      // Junk on the request inputs while busy must not disturb the sequence.
      req_valid = (i < exp_q.size() - 1) ? 1'($urandom) : 1'b0;
      req_sel   = 3'($urandom);
      dwell     = 8'($urandom);
      abort     = (i == v.ab);
    end
    abort     = 1'b0;
    req_valid = 1'b0;
    if (summary) begin
      check({name, "_busy_cycles"}, 6'(seen_busy), 6'(v.exp_busy));
      check({name, "_done_pulses"}, 6'(seen_done), 6'(v.exp_done));
      check({name, "_codes_seen"}, {3'b000, seen_codes}, {3'b000, v.exp_seen});
    end
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    tbl[0] = '{sel: 3'b001, dw: 2,   ab: -1, ab_req: 1'b0, exp_busy: 3,   exp_done: 1, exp_seen: 3'b001};
    tbl[1] = '{sel: 3'b111, dw: 0,   ab: -1, ab_req: 1'b0, exp_busy: 5,   exp_done: 1, exp_seen: 3'b111};
    tbl[2] = '{sel: 3'b101, dw: 1,   ab: -1, ab_req: 1'b0, exp_busy: 5,   exp_done: 1, exp_seen: 3'b101};
    tbl[3] = '{sel: 3'b110, dw: 3,   ab: 1,  ab_req: 1'b0, exp_busy: 2,   exp_done: 0, exp_seen: 3'b010};
    tbl[4] = '{sel: 3'b000, dw: 5,   ab: -1, ab_req: 1'b0, exp_busy: 0,   exp_done: 0, exp_seen: 3'b000};
    tbl[5] = '{sel: 3'b011, dw: 4,   ab: 5,  ab_req: 1'b0, exp_busy: 6,   exp_done: 0, exp_seen: 3'b001};
    tbl[6] = '{sel: 3'b001, dw: 0,   ab: 1,  ab_req: 1'b0, exp_busy: 1,   exp_done: 1, exp_seen: 3'b001};
    tbl[7] = '{sel: 3'b100, dw: 1,   ab: -1, ab_req: 1'b1, exp_busy: 2,   exp_done: 1, exp_seen: 3'b100};
    tbl[8] = '{sel: 3'b010, dw: 0,   ab: -1, ab_req: 1'b0, exp_busy: 1,   exp_done: 1, exp_seen: 3'b010};
    tbl[9] = '{sel: 3'b100, dw: 255, ab: -1, ab_req: 1'b0, exp_busy: 256, exp_done: 1, exp_seen: 3'b100};

    rst       = 1'b1;
    req_valid = 1'b1;
    req_sel   = 3'b111;
    dwell     = 8'd0;
    abort     = 1'b1;
    repeat (2) @(negedge clk);
    sample("reset", ExpIdle);
    rst       = 1'b0;
    req_valid = 1'b0;
    abort     = 1'b0;
    @(negedge clk);
    sample("post_reset_idle", ExpIdle);

    for (int t = 0; t < 10; t++) run_req($sformatf("tbl%0d", t), tbl[t], 1'b1);

    // Reset in the first guard of a 111 sequence, with abort and a request also high.
    build_trace(3'b111, 3, -1);
    req_valid = 1'b1;
    req_sel   = 3'b111;
    dwell     = 8'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      sample($sformatf("rstseq_cyc%0d", i), exp_q[i]);
      req_valid = 1'b0;
    end
    rst       = 1'b1;
    abort     = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    sample("rst_mid_guard", ExpIdle);
    rst       = 1'b0;
    abort     = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      sample($sformatf("after_rst_quiet%0d", i), ExpIdle);
    end

    for (int r = 0; r < 40; r++) begin
      rv.sel    = 3'($urandom);
      rv.dw     = int'($urandom_range(0, 6));
      rv.ab     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3 * (rv.dw + 2))) : -1;
      rv.ab_req = 1'($urandom);
      rv.exp_busy = 0;
      rv.exp_done = 0;
      rv.exp_seen = 3'b000;
      run_req($sformatf("rand%0d", r), rv, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/enable_code_sequencer.md
ENABLE_CODE_SEQUENCER -- requirements
Module: enable_code_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk in, rst in.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 req_valid  input  1  request present; accepted on a rising edge where req_valid=1 and req_ready=1.
REQ-005 req_sel  input  3  code-select mask: bit0 -> code 001, bit1 -> code 010, bit2 -> code 100.
REQ-006 dwell  input  8  hold length; each selected code is driven for dwell+1 cycles.
REQ-007 abort  input  1  cancel the sequence in progress.
REQ-008 A, B, C  output  1 each  registered 3-bit enable code, A is MSB, fed to the enable decoder.
REQ-009 req_ready  output  1  high only in IDLE.
REQ-010 busy  output  1  high in DRIVE or GUARD.
REQ-011 done  output  1  one-cycle pulse when a sequence completes normally.

Function
REQ-012 Code set: 000 = no enable, 001 = S1+S4, 010 = S1+S3, 100 = S2+S3; no other value SHALL ever appear on {A,B,C}.
REQ-013 All outputs SHALL be registered.
REQ-014 States: IDLE, DRIVE, GUARD, DONE.
REQ-015 IDLE: {A,B,C}=000, req_ready=1. On acceptance with req_sel!=000, latch req_sel and dwell, set idx to the lowest set bit, go to DRIVE.
REQ-016 An accepted request with req_sel=000 SHALL be ignored: the block stays in IDLE and pulses no done.
REQ-017 Latency: with acceptance at edge k, the first code SHALL appear on {A,B,C} from edge k+1.
REQ-018 DRIVE: {A,B,C}=code(idx) for exactly dwell+1 cycles, counted by the latched dwell. Changes to req_sel or dwell during the sequence SHALL have no effect.
REQ-019 DRIVE exit: if a higher selected bit remains, go to GUARD; otherwise go to DONE.
REQ-020 GUARD: {A,B,C}=000 for exactly 1 cycle (break-before-make), then DRIVE with idx set to the next higher selected bit.
REQ-021 Ordering: codes SHALL be played in ascending bit order (001, 010, 100), skipping unselected bits.
REQ-022 DONE: {A,B,C}=000, done=1 for 1 cycle, then IDLE; req_ready returns to 1 on the following cycle.
REQ-023 abort=1 in DRIVE or GUARD: the next state SHALL be IDLE with {A,B,C}=000, no done pulse, and the dwell counter cleared.
REQ-024 abort in IDLE or DONE SHALL be ignored; in DONE the done pulse still occurs.
REQ-025 abort together with a req_valid in IDLE: the request SHALL be accepted.
REQ-026 dwell=0: each code SHALL be held for 1 cycle.
REQ-027 dwell=255: each code SHALL be held for 256 cycles; the counter SHALL NOT wrap early.

Reset
REQ-028 While rst=1 at a clock edge: state=IDLE, {A,B,C}=000, busy=0, done=0, req_ready=1, counter=0, latched mask=000.
REQ-029 Reset mid-sequence SHALL take effect on the next edge; no done pulse and no partial code SHALL follow it.
REQ-030 rst SHALL take priority over abort and req_valid.

Structure
REQ-031 The code constants (CODE_NONE=000, CODE_S1S4=001, CODE_S1S3=010, CODE_S2S3=100) and the state encodings SHALL live in a shared project constants include, so the decoder and this block use the same values.
REQ-032 The dwell timing SHALL be a sub-module, dwell_counter (8-bit load/count/terminal-count with synchronous clear), instantiated once.

Verification
REQ-033 Mask 001, dwell=2 -> ABC = 001 for 3 cycles, then 000, done pulse in the DONE cycle, req_ready=1 one cycle later.
REQ-034 Mask 111, dwell=0 -> ABC sequence 001, 000, 010, 000, 100, 000(done); busy=1 for 5 cycles.
REQ-035 Mask 101, dwell=1 -> ABC 001,001,000,100,100, then done; 010 is never driven.
REQ-036 Mask 110, dwell=3, abort in the 2nd cycle of 010 -> ABC=000 next cycle, IDLE, no done; a new request is accepted on the following edge.
REQ-037 rst asserted mid-GUARD with mask 111 -> all outputs at reset values on the next edge; mask 000 request -> no activity, no done.
REQ-038 Dwell=255, mask 100 -> exactly 256 cycles of 100; a checker asserts {A,B,C} is always one of {000,001,010,100}.
